// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: restoring radix-2 divide, multiply via registered 32x32 product,
// or a 32-step shift-add when MULDIV_ITER_MULT_EN is defined. Stall is combinational.
module hilo_muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [7:0]  alu_ctrl,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] rdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] ma_q, ma_d, mb_q, mb_d;
   logic [63:0] rq_q, rq_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        rneg_q, rneg_d, remneg_q, remneg_d;
   logic        busy_q, busy_d;

   logic        is_md, is_mul, signed_op, start, mv_ok;
   logic [31:0] abs_a, abs_b;
   logic [64:0] dsh;
   logic [32:0] dtrial;
   logic [63:0] div_step;
   logic [63:0] prod;
`ifdef MULDIV_ITER_MULT_EN
   logic [32:0] msum;
   logic [63:0] mul_step;
`endif

   always_comb begin
      is_md     = |alu_ctrl[7:4];
      is_mul    = alu_ctrl[7] | alu_ctrl[6];
      // MULT outranks MULTU, DIV outranks DIVU
      signed_op = alu_ctrl[7] | (~alu_ctrl[6] & alu_ctrl[5]);
      start     = (state_q == S_IDLE) & op_valid & ~flush & is_md;
      mv_ok     = (state_q == S_IDLE) & op_valid & ~flush & ~is_md;
      abs_a     = (signed_op & src_a[31]) ? -src_a : src_a;
      abs_b     = (signed_op & src_b[31]) ? -src_b : src_b;

      // Remainder can momentarily need 33 bits after the shift
      dsh    = {rq_q, 1'b0};
      dtrial = dsh[64:32] - {1'b0, mb_q};
      div_step = dtrial[32] ? dsh[63:0] : {dtrial[31:0], dsh[31:1], 1'b1};

`ifdef MULDIV_ITER_MULT_EN
      msum     = {1'b0, rq_q[63:32]} + (rq_q[0] ? {1'b0, ma_q} : 33'd0);
      mul_step = {msum, rq_q[31:1]};
      prod     = rneg_q ? -mul_step : mul_step;
`else
      prod     = {32'd0, ma_q} * {32'd0, mb_q};
      prod     = rneg_q ? -prod : prod;
`endif

      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      rq_d     = rq_q;
      cnt_d    = cnt_q;
      rneg_d   = rneg_q;
      remneg_d = remneg_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ma_d     = abs_a;
               mb_d     = abs_b;
               rneg_d   = signed_op & (src_a[31] ^ src_b[31]);
               remneg_d = signed_op & src_a[31];
               cnt_d    = 5'd0;
               rq_d     = {32'd0, is_mul ? abs_b : abs_a};
               if (is_mul)
                  state_d = S_MUL;
               else if (src_b == 32'd0)
                  state_d = S_DONE;
               else
                  state_d = S_DIV;
            end else if (mv_ok) begin
               if (alu_ctrl[1])
                  hi_d = src_a;
               else if (alu_ctrl[0])
                  lo_d = src_a;
            end
         end
         S_MUL: begin
`ifdef MULDIV_ITER_MULT_EN
            rq_d  = mul_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               hi_d    = prod[63:32];
               lo_d    = prod[31:0];
               state_d = S_DONE;
            end
`else
            hi_d    = prod[63:32];
            lo_d    = prod[31:0];
            state_d = S_DONE;
`endif
         end
         S_DIV: begin
            rq_d  = div_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               lo_d    = rneg_q   ? -div_step[31:0]  : div_step[31:0];
               hi_d    = remneg_q ? -div_step[63:32] : div_step[63:32];
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Cancel wins over both a new start and a pending final write
      if (flush) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end

      busy_d = (state_d == S_MUL) | (state_d == S_DIV);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         ma_q     <= 32'd0;
         mb_q     <= 32'd0;
         rq_q     <= 64'd0;
         cnt_q    <= 5'd0;
         rneg_q   <= 1'b0;
         remneg_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         rq_q     <= rq_d;
         cnt_q    <= cnt_d;
         rneg_q   <= rneg_d;
         remneg_q <= remneg_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      stall = start | (state_q == S_MUL) | (state_q == S_DIV);
      if (alu_ctrl[3])
         rdata = hi_q;
      else if (alu_ctrl[2])
         rdata = lo_q;
      else
         rdata = 32'd0;
      hi   = hi_q;
      lo   = lo_q;
      busy = busy_q;
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: multiply, divide, divide-by-zero, flush, reset abort, moves.
module tb_hilo_muldiv_unit;

   localparam logic [7:0] C_MULT  = 8'h80;
   localparam logic [7:0] C_MULTU = 8'h40;
   localparam logic [7:0] C_DIV   = 8'h20;
   localparam logic [7:0] C_DIVU  = 8'h10;
   localparam logic [7:0] C_MFHI  = 8'h08;
   localparam logic [7:0] C_MFLO  = 8'h04;
   localparam logic [7:0] C_MTHI  = 8'h02;
   localparam logic [7:0] C_MTLO  = 8'h01;
`ifdef MULDIV_ITER_MULT_EN
   localparam int MUL_STALL = 33;
`else
   localparam int MUL_STALL = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [7:0]  alu_ctrl;
   logic [31:0] src_a, src_b;
   logic        flush;
   logic        stall;
   logic [31:0] rdata, hi, lo;
   logic        busy;

   int total  = 0;
   int passed = 0;

   hilo_muldiv_unit dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .alu_ctrl (alu_ctrl),
      .src_a    (src_a),
      .src_b    (src_b),
      .flush    (flush),
      .stall    (stall),
      .rdata    (rdata),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp)
         passed++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds the instruction while stalled, releases it after the no-stall cycle.
   task automatic run_op(input logic [7:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         output int n);
      op_valid = 1'b1;
      alu_ctrl = ctrl;
      src_a    = a;
      src_b    = b;
      n = 0;
      #1;
      while (stall && n < 200) begin
         n++;
         tick();
         #1;
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      alu_ctrl = 8'h00;
   endtask

   initial begin
      int n;
      rst      = 1'b1;
      op_valid = 1'b0;
      alu_ctrl = 8'h00;
      src_a    = 32'd0;
      src_b    = 32'd0;
      flush    = 1'b0;
      #3;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      run_op(C_DIV, 32'hFFFF_FFF9, 32'd2, n);
      check("div_stall", n, 33);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);

      run_op(C_DIV, 32'd7, 32'hFFFF_FFFE, n);
      check("div2_lo", lo, 32'hFFFF_FFFD);
      check("div2_hi", hi, 32'd1);

      run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      check("multu_stall", n, MUL_STALL);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      run_op(C_MULT, 32'hFFFF_FFFD, 32'd5, n);
      check("mult_stall", n, MUL_STALL);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFF1);

      run_op(C_MTHI, 32'h11, 32'd0, n);
      check("mthi_stall", n, 0);
      run_op(C_MTLO, 32'h22, 32'd0, n);
      check("preset_hi", hi, 32'h11);
      check("preset_lo", lo, 32'h22);

      run_op(C_DIVU, 32'd100, 32'd0, n);
      check("dz_stall", n, 1);
      check("dz_hi", hi, 32'h11);
      check("dz_lo", lo, 32'h22);

      // Flush in the 10th DIV cycle
      op_valid = 1'b1;
      alu_ctrl = C_DIVU;
      src_a    = 32'd100;
      src_b    = 32'd7;
      for (int i = 0; i < 10; i++) tick();
      check("fl_busy_mid", {31'd0, busy}, 32'd1);
      check("fl_stall_mid", {31'd0, stall}, 32'd1);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      op_valid = 1'b0;
      alu_ctrl = 8'h00;
      #1;
      check("fl_stall", {31'd0, stall}, 32'd0);
      check("fl_busy", {31'd0, busy}, 32'd0);
      check("fl_hi", hi, 32'h11);
      check("fl_lo", lo, 32'h22);

      // Flush in the issue cycle: nothing starts
      op_valid = 1'b1;
      alu_ctrl = C_DIVU;
      flush    = 1'b1;
      #1;
      check("fi_stall", {31'd0, stall}, 32'd0);
      tick();
      flush    = 1'b0;
      op_valid = 1'b0;
      alu_ctrl = 8'h00;
      tick();
      check("fi_busy", {31'd0, busy}, 32'd0);
      check("fi_stall2", {31'd0, stall}, 32'd0);

      // Move then read back the next cycle
      op_valid = 1'b1;
      alu_ctrl = C_MTHI;
      src_a    = 32'hDEAD_BEEF;
      #1;
      check("mthi_nostall", {31'd0, stall}, 32'd0);
      tick();
      alu_ctrl = C_MFHI;
      #1;
      check("mfhi_rdata", rdata, 32'hDEAD_BEEF);
      check("mfhi_stall", {31'd0, stall}, 32'd0);
      tick();
      alu_ctrl = C_MTLO;
      src_a    = 32'd5;
      tick();
      alu_ctrl = C_MFLO;
      #1;
      check("mflo_rdata", rdata, 32'd5);
      tick();
      op_valid = 1'b0;
      alu_ctrl = 8'h00;
      tick();

      // Reset in the 5th DIV cycle
      op_valid = 1'b1;
      alu_ctrl = C_DIVU;
      src_a    = 32'd100;
      src_b    = 32'd7;
      for (int i = 0; i < 5; i++) tick();
      rst      = 1'b1;
      op_valid = 1'b0;
      alu_ctrl = 8'h00;
      #1;
      check("ar_hi", hi, 32'd0);
      check("ar_lo", lo, 32'd0);
      check("ar_stall", {31'd0, stall}, 32'd0);
      check("ar_busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      run_op(C_DIVU, 32'd9, 32'd3, n);
      check("post_stall", n, 33);
      check("post_lo", lo, 32'd3);
      check("post_hi", hi, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
